// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU and the loader.
// Each grant moves one word: IDLE -> ACCESS (strobes) -> DONE (ack), all outputs registered.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ldr_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_read_en,
    output logic                  ram_write_en,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rd_en_q;
    logic                  wr_en_q;
    logic                  cpu_ack_q;
    logic                  ldr_ack_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] ldr_rdata_q;
    logic                  busy_q;
    logic                  grant_q;

    // Under contention the side that did not own the last transaction wins.
    logic win_ldr_d;
    assign win_ldr_d = (cpu_req & ldr_req) ? ~grant_q : ldr_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            busy_q      <= 1'b0;
            grant_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        grant_q <= win_ldr_d;
                        addr_q  <= win_ldr_d ? ldr_addr  : cpu_addr;
                        we_q    <= win_ldr_d ? ldr_we    : cpu_we;
                        wdata_q <= win_ldr_d ? ldr_wdata : cpu_wdata;
                        rd_en_q <= win_ldr_d ? ~ldr_we   : ~cpu_we;
                        wr_en_q <= win_ldr_d ? ldr_we    : cpu_we;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (grant_q) ldr_rdata_q <= ram_data;
                        else         cpu_rdata_q <= ram_data;
                    end
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    if (grant_q) ldr_ack_q <= 1'b1;
                    else         cpu_ack_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    cpu_ack_q <= 1'b0;
                    ldr_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_data     = wr_en_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_address  = addr_q;
    assign ram_read_en  = rd_en_q;
    assign ram_write_en = wr_en_q;
    assign cpu_ack      = cpu_ack_q;
    assign ldr_ack      = ldr_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign ldr_rdata    = ldr_rdata_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: 16x8 RAM model on the shared bus plus a transaction-level reference model.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [3:0] cpu_addr = 4'h0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic       ldr_req = 1'b0, ldr_we = 1'b0;
    logic [3:0] ldr_addr = 4'h0;
    logic [7:0] ldr_wdata = 8'h00;
    logic [7:0] ldr_rdata;
    logic       ldr_ack;
    logic [3:0] ram_address;
    logic       ram_read_en, ram_write_en, busy, grant_id;
    wire  [7:0] ram_data;

    int errors = 0;
    int checks = 0;

    ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .ram_address(ram_address), .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
        .ram_data(ram_data), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(int i);
        case (i)
            1:       return 8'h00;
            2:       return 8'h3C;
            3:       return 8'hA5;
            7:       return 8'hC3;
            15:      return 8'h11;
            default: return 8'(i * 23 + 1);
        endcase
    endfunction

    // RAM: reloads its known pattern while reset is held, answers reads combinationally
    logic [7:0] mem [16];
    assign ram_data = ram_write_en ? 8'bz : mem[ram_address];
    always @(posedge clk) begin
        if (!rst) for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        else if (ram_write_en) mem[ram_address] <= ram_data;
    end

    // Reference model: one transaction at a time, three cycles each, round-robin pointer
    int         m_phase;
    bit         m_owner, m_last, m_we;
    logic [3:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata [2];
    logic [7:0] ref_mem [16];
    bit   [1:0] m_ack, m_granted;

    task automatic model_reset();
        m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
        m_addr = 4'h0; m_wdata = 8'h00; m_ack = 2'b00;
        m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic model_step();
        bit w;
        m_granted = 2'b00;
        if (!rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (cpu_req || ldr_req) begin
                w = (cpu_req && ldr_req) ? !m_last : ldr_req;
                m_owner = w; m_last = w; m_granted[w] = 1'b1;
                m_we    = w ? ldr_we    : cpu_we;
                m_addr  = w ? ldr_addr  : cpu_addr;
                m_wdata = w ? ldr_wdata : cpu_wdata;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rdata[m_owner] = ref_mem[m_addr];
            m_ack[m_owner] = 1'b1;
            m_phase = 2;
        end else begin
            m_ack = 2'b00;
            m_phase = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        tick(); tick();
        checks += 8;
        if (ram_read_en !== 1'b0)  begin errors++; $display("FAIL reset_rd got=%b want=0", ram_read_en); end
        if (ram_write_en !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b want=0", ram_write_en); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (grant_id !== 1'b1)     begin errors++; $display("FAIL reset_grant got=%b want=1", grant_id); end
        if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b%b want=00", cpu_ack, ldr_ack); end
        if (cpu_rdata !== 8'h00)   begin errors++; $display("FAIL reset_cpu_rdata got=%h want=00", cpu_rdata); end
        if (ldr_rdata !== 8'h00)   begin errors++; $display("FAIL reset_ldr_rdata got=%h want=00", ldr_rdata); end
        if (ram_address !== 4'h0)  begin errors++; $display("FAIL reset_addr got=%h want=0", ram_address); end
        rst = 1'b1;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks += 3;
            if (busy !== 1'b0 || ram_read_en !== 1'b0 || ram_write_en !== 1'b0) begin
                errors++; $display("FAIL idle_ctrl cyc=%0d busy/rd/wr got=%b%b%b want=000", c, busy, ram_read_en, ram_write_en);
            end
            if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0) begin
                errors++; $display("FAIL idle_ack cyc=%0d got=%b%b want=00", c, cpu_ack, ldr_ack);
            end
            if (ram_data !== mem[ram_address]) begin
                errors++; $display("FAIL idle_bus cyc=%0d got=%h want=%h (bus not released)", c, ram_data, mem[ram_address]);
            end
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        tick();
        cpu_req = 1'b0;
        checks += 4;
        if (ram_read_en !== 1'b1)  begin errors++; $display("FAIL rd_strobe got=%b want=1", ram_read_en); end
        if (ram_write_en !== 1'b0) begin errors++; $display("FAIL rd_wr got=%b want=0", ram_write_en); end
        if (ram_address !== 4'h3)  begin errors++; $display("FAIL rd_addr got=%h want=3", ram_address); end
        if (busy !== 1'b1)         begin errors++; $display("FAIL rd_busy got=%b want=1", busy); end
        tick();
        checks += 4;
        if (cpu_ack !== 1'b1)      begin errors++; $display("FAIL rd_ack got=%b want=1", cpu_ack); end
        if (cpu_rdata !== 8'hA5)   begin errors++; $display("FAIL rd_data got=%h want=a5", cpu_rdata); end
        if (ldr_ack !== 1'b0)      begin errors++; $display("FAIL rd_ldr_ack got=%b want=0", ldr_ack); end
        if (ram_read_en !== 1'b0)  begin errors++; $display("FAIL rd_strobe_drop got=%b want=0", ram_read_en); end
        tick();
        checks += 3;
        if (cpu_ack !== 1'b0)      begin errors++; $display("FAIL rd_ack_drop got=%b want=0", cpu_ack); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL rd_busy_drop got=%b want=0", busy); end
        if (grant_id !== 1'b0)     begin errors++; $display("FAIL rd_grant got=%b want=0", grant_id); end
    endtask

    task automatic test_ldr_write();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'h5C;
        tick();
        ldr_req = 1'b0;
        checks += 4;
        if (ram_write_en !== 1'b1) begin errors++; $display("FAIL wr_strobe got=%b want=1", ram_write_en); end
        if (ram_read_en !== 1'b0)  begin errors++; $display("FAIL wr_rd got=%b want=0", ram_read_en); end
        if (ram_data !== 8'h5C)    begin errors++; $display("FAIL wr_bus got=%h want=5c", ram_data); end
        if (ram_address !== 4'hF)  begin errors++; $display("FAIL wr_addr got=%h want=f", ram_address); end
        tick();
        checks += 3;
        if (ldr_ack !== 1'b1)      begin errors++; $display("FAIL wr_ack got=%b want=1", ldr_ack); end
        if (ram_write_en !== 1'b0) begin errors++; $display("FAIL wr_strobe_drop got=%b want=0", ram_write_en); end
        if (ldr_rdata !== 8'h00)   begin errors++; $display("FAIL wr_rdata_kept got=%h want=00", ldr_rdata); end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hF;
        tick();
        cpu_req = 1'b0;
        tick();
        checks += 2;
        if (cpu_ack !== 1'b1)      begin errors++; $display("FAIL rb_ack got=%b want=1", cpu_ack); end
        if (cpu_rdata !== 8'h5C)   begin errors++; $display("FAIL rb_data got=%h want=5c", cpu_rdata); end
        tick();
    endtask

    task automatic test_late_change();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h2;
        tick();
        cpu_addr = 4'h7;
        checks += 1;
        if (ram_address !== 4'h2)  begin errors++; $display("FAIL late_addr got=%h want=2", ram_address); end
        tick();
        checks += 3;
        if (ram_address !== 4'h2)  begin errors++; $display("FAIL late_addr_hold got=%h want=2", ram_address); end
        if (cpu_ack !== 1'b1)      begin errors++; $display("FAIL late_ack got=%b want=1", cpu_ack); end
        if (cpu_rdata !== 8'h3C)   begin errors++; $display("FAIL late_data got=%h want=3c", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int ack_cyc[$];
        bit ack_who[$];
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h7;
        tick();
        rst = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks += 1;
            if (ram_read_en === 1'b1 && ram_write_en === 1'b1) begin
                errors++; $display("FAIL cont_overlap cyc=%0d rd=1 wr=1 want never both", c);
            end
            if (cpu_ack === 1'b1) begin ack_cyc.push_back(c); ack_who.push_back(1'b0); end
            if (ldr_ack === 1'b1) begin ack_cyc.push_back(c); ack_who.push_back(1'b1); end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        checks += 3;
        if (ack_who.size() !== 4) begin errors++; $display("FAIL cont_count got=%0d want=4", ack_who.size()); end
        if (cpu_rdata !== 8'hA5)  begin errors++; $display("FAIL cont_cpu_data got=%h want=a5", cpu_rdata); end
        if (ldr_rdata !== 8'hC3)  begin errors++; $display("FAIL cont_ldr_data got=%h want=c3", ldr_rdata); end
        for (int i = 0; i < ack_who.size() && i < 4; i++) begin
            checks += 2;
            if (ack_who[i] !== 1'(i % 2)) begin errors++; $display("FAIL cont_order idx=%0d got=%0d want=%0d", i, ack_who[i], i % 2); end
            if (ack_cyc[i] !== 2 + 3 * i) begin errors++; $display("FAIL cont_timing idx=%0d got=%0d want=%0d", i, ack_cyc[i], 2 + 3 * i); end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_write();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h1; ldr_wdata = 8'hAA;
        tick();
        ldr_req = 1'b0;
        checks += 1;
        if (ram_write_en !== 1'b1) begin errors++; $display("FAIL mid_wr_start got=%b want=1", ram_write_en); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks += 4;
        if (ram_write_en !== 1'b0) begin errors++; $display("FAIL mid_wr_drop got=%b want=0", ram_write_en); end
        if (ldr_ack !== 1'b0)      begin errors++; $display("FAIL mid_ack got=%b want=0", ldr_ack); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
        if (grant_id !== 1'b1)     begin errors++; $display("FAIL mid_grant got=%b want=1", grant_id); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h2;
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        cpu_req = 1'b0; ldr_req = 1'b0;
        checks += 2;
        if (grant_id !== 1'b0)     begin errors++; $display("FAIL mid_first_win got=%b want=0", grant_id); end
        if (ram_read_en !== 1'b1)  begin errors++; $display("FAIL mid_rd got=%b want=1", ram_read_en); end
        tick();
        checks += 1;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h00) begin
            errors++; $display("FAIL mid_after ack/data got=%b/%h want=1/00", cpu_ack, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        bit pend_c = 1'b0, pend_l = 1'b0;
        rst = 1'b0;
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!pend_c) begin
                cpu_req = ($urandom_range(0, 9) < 6);
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 4'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom_range(0, 255));
                pend_c = cpu_req;
            end
            if (!pend_l) begin
                ldr_req = ($urandom_range(0, 9) < 6);
                ldr_we = 1'($urandom_range(0, 1));
                ldr_addr = 4'($urandom_range(0, 15));
                ldr_wdata = 8'($urandom_range(0, 255));
                pend_l = ldr_req;
            end
            tick();
            if (m_granted[0]) pend_c = 1'b0;
            if (m_granted[1]) pend_l = 1'b0;
            checks += 7;
            if (ram_read_en !== (m_phase == 1 && !m_we)) begin errors++; $display("FAIL rnd_rd cyc=%0d got=%b", c, ram_read_en); end
            if (ram_write_en !== (m_phase == 1 && m_we)) begin errors++; $display("FAIL rnd_wr cyc=%0d got=%b", c, ram_write_en); end
            if (busy !== (m_phase != 0))                 begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b", c, busy); end
            if ({ldr_ack, cpu_ack} !== m_ack)            begin errors++; $display("FAIL rnd_ack cyc=%0d got=%b%b want=%b", c, ldr_ack, cpu_ack, m_ack); end
            if (grant_id !== m_last)                     begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", c, grant_id, m_last); end
            if (cpu_rdata !== m_rdata[0])                begin errors++; $display("FAIL rnd_cpu_rdata cyc=%0d got=%h want=%h", c, cpu_rdata, m_rdata[0]); end
            if (ldr_rdata !== m_rdata[1])                begin errors++; $display("FAIL rnd_ldr_rdata cyc=%0d got=%h want=%h", c, ldr_rdata, m_rdata[1]); end
            if (m_phase == 1) begin
                checks += 1;
                if (ram_address !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", c, ram_address, m_addr); end
                if (m_we) begin
                    checks += 1;
                    if (ram_data !== m_wdata) begin errors++; $display("FAIL rnd_bus cyc=%0d got=%h want=%h", c, ram_data, m_wdata); end
                end
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 16; i++) begin
            checks += 1;
            if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rnd_mem addr=%0d got=%h want=%h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle();
        test_cpu_read();
        test_ldr_write();
        test_late_change();
        test_contention();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
